// File: rtl/hdmi_timing_gen.sv
// Video timing generator: free-running h/v counters, a pixel request port, and a
// delay line that aligns syncs, data enable and markers with the returned pixel.
module hdmi_timing_gen #(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 62,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 30,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 2,
    parameter int CW       = 8,
    parameter int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    parameter int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    parameter int XW       = $clog2(H_TOTAL),
    parameter int YW       = $clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] fill,
    input  logic [3*CW-1:0] pix_in,
    output logic            req_valid,
    output logic [XW-1:0]   req_x,
    output logic [YW-1:0]   req_y,
    output logic [3*CW-1:0] data,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            frame_start,
    output logic            line_start
);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam int BAR_W = H_ACTIVE / 8;

    typedef struct packed {
        logic          active;
        logic          hs;
        logic          vs;
        logic          frame;
        logic          line;
        logic [1:0]    mode;
        logic [XW-1:0] x;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{active: 1'b0, hs: ~HS_POL, vs: ~VS_POL,
                                      frame: 1'b0, line: 1'b0, mode: 2'd0, x: '0};

    logic [XW-1:0]   h_q, h_d;
    logic [YW-1:0]   v_q, v_d;
    logic [1:0]      mode_q, mode_d;
    logic [31:0]     h_ext, v_ext;
    logic [2:0]      bar;
    stage_t          cur_s, tap_s;
    logic [3*CW-1:0] data_q, data_d;
    logic            de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic            frame_q, frame_d, line_q, line_d;

    always_comb begin
        h_d    = h_q + XW'(1);
        v_d    = v_q;
        mode_d = mode_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d    = '0;
                mode_d = mode;
            end else begin
                v_d = v_q + YW'(1);
            end
        end
    end

    // Flags for the current counter position; the frame's mode rides along so
    // pixels already in flight keep the pattern they were requested under.
    always_comb begin
        h_ext        = 32'(h_q);
        v_ext        = 32'(v_q);
        cur_s.active = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        cur_s.hs     = ((h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC))
                       ? HS_POL : ~HS_POL;
        cur_s.vs     = ((v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC))
                       ? VS_POL : ~VS_POL;
        cur_s.frame  = (h_q == '0) && (v_q == '0);
        cur_s.line   = (h_q == '0) && (v_ext < V_ACTIVE);
        cur_s.mode   = mode_q;
        cur_s.x      = h_q;
        req_valid    = cur_s.active;
        req_x        = h_q;
        req_y        = v_q;
    end

    // tap_s lines up with the cycle in which pix_in answers the request.
    if (PIX_LAT == 0) begin : g_nolat
        always_comb tap_s = cur_s;
    end else begin : g_lat
        stage_t pipe_q [PIX_LAT];
        stage_t pipe_d [PIX_LAT];

        always_comb begin
            pipe_d[0] = cur_s;
            for (int unsigned i = 1; i < PIX_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int unsigned i = 0; i < PIX_LAT; i++) begin
                    pipe_q[i] <= STAGE_IDLE;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        always_comb tap_s = pipe_q[PIX_LAT-1];
    end

    always_comb begin
        bar     = 3'(32'(tap_s.x) / BAR_W);
        de_d    = tap_s.active;
        hsync_d = tap_s.hs;
        vsync_d = tap_s.vs;
        frame_d = tap_s.frame;
        line_d  = tap_s.line;
        data_d  = '0;
        if (tap_s.active) begin
            case (tap_s.mode)
                2'd1:    data_d = {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};
                2'd2:    data_d = fill;
                default: data_d = pix_in;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q     <= '0;
            v_q     <= '0;
            mode_q  <= mode;
            data_q  <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            frame_q <= frame_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        data        = data_q;
        de          = de_q;
        hsync       = hsync_q;
        vsync       = vsync_q;
        frame_start = frame_q;
        line_start  = line_q;
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a small 14x7 raster: arithmetic reference model
// of the raster position, directed scenarios and randomized mode/fill/reset runs.
module tb_hdmi_timing_gen;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int PIX_LAT = 2, CW = 8;
    localparam int H_TOTAL = 14, V_TOTAL = 7, FRAME = H_TOTAL * V_TOTAL, L = PIX_LAT + 1;
    localparam int XW = 4, YW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [3*CW-1:0] fill = '0;
    logic [3*CW-1:0] pix_in = '0;
    logic            req_valid;
    logic [XW-1:0]   req_x;
    logic [YW-1:0]   req_y;
    logic [3*CW-1:0] data;
    logic            hsync, vsync, de, frame_start, line_start;

    always #5 clk = ~clk;

    hdmi_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(PIX_LAT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .fill(fill), .pix_in(pix_in),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .data(data),
        .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start), .line_start(line_start)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: n = cycles since reset release, mode per frame of epoch.
    int          n = 0;
    int          cycle = 0;
    int          frame_mode [256];
    logic [23:0] bars [8];
    int          hist_x [3];
    int          hist_y [3];
    int          last_fs = -1, fs_gap = 0;
    int          cnt_fs = 0, cnt_ls = 0, cnt_de = 0, cnt_hs_low = 0, cnt_vs_low = 0;

    task automatic step(input logic r, input logic [1:0] m, input logic [23:0] f);
        int          s, hs, vs, hn, vn, fm;
        logic        e_de, e_hs, e_vs, e_fs, e_ls, e_req;
        logic [23:0] e_data;
        rst  = r;
        mode = m;
        fill = f;
        @(posedge clk);
        #1;
        cycle++;
        if (!r) begin
            n = 0;
            frame_mode[0] = int'(m);
            last_fs = -1;
        end else begin
            if ((n % FRAME) == FRAME - 1 && (n / FRAME + 1) < 256)
                frame_mode[n / FRAME + 1] = int'(m);
            n++;
        end

        // Pixel source answers each request PIX_LAT cycles later.
        hist_x[2] = hist_x[1]; hist_x[1] = hist_x[0]; hist_x[0] = int'(req_x);
        hist_y[2] = hist_y[1]; hist_y[1] = hist_y[0]; hist_y[0] = int'(req_y);
        pix_in = {8'h00, 8'(hist_x[2]), 8'(hist_y[2])};

        hn = n % H_TOTAL;
        vn = (n / H_TOTAL) % V_TOTAL;
        e_req = (hn < H_ACTIVE) && (vn < V_ACTIVE);
        check_eq("req_valid", 32'(req_valid), 32'(e_req));
        if (e_req) begin
            check_eq("req_x", 32'(req_x), 32'(hn));
            check_eq("req_y", 32'(req_y), 32'(vn));
        end

        if (n >= L) begin
            s    = n - L;
            hs   = s % H_TOTAL;
            vs   = (s / H_TOTAL) % V_TOTAL;
            fm   = ((s / FRAME) < 256) ? frame_mode[s / FRAME] : 0;
            e_de = (hs < H_ACTIVE) && (vs < V_ACTIVE);
            e_hs = !((hs >= H_ACTIVE + H_FP) && (hs < H_ACTIVE + H_FP + H_SYNC));
            e_vs = !((vs >= V_ACTIVE + V_FP) && (vs < V_ACTIVE + V_FP + V_SYNC));
            e_fs = (s % FRAME) == 0;
            e_ls = (hs == 0) && (vs < V_ACTIVE);
            if (!e_de)        e_data = '0;
            else if (fm == 1) e_data = bars[hs / (H_ACTIVE / 8)];
            else if (fm == 2) e_data = f;
            else              e_data = {8'h00, 8'(hs), 8'(vs)};
        end else begin
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_ls = 1'b0; e_data = '0;
        end
        check_eq("de", 32'(de), 32'(e_de));
        check_eq("hsync", 32'(hsync), 32'(e_hs));
        check_eq("vsync", 32'(vsync), 32'(e_vs));
        check_eq("frame_start", 32'(frame_start), 32'(e_fs));
        check_eq("line_start", 32'(line_start), 32'(e_ls));
        check_eq("data", 32'(data), 32'(e_data));

        if (frame_start === 1'b1) begin
            if (last_fs >= 0) fs_gap = cycle - last_fs;
            last_fs = cycle;
            cnt_fs++;
        end
        if (line_start === 1'b1) cnt_ls++;
        if (de === 1'b1)         cnt_de++;
        if (hsync === 1'b0)      cnt_hs_low++;
        if (vsync === 1'b0)      cnt_vs_low++;
    endtask

    initial begin
        int len, rlen;
        logic [1:0]  rm;
        logic [23:0] rf;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        foreach (frame_mode[i]) frame_mode[i] = 0;
        foreach (hist_x[i]) begin hist_x[i] = 0; hist_y[i] = 0; end

        // Reset, release in pass-through, measure one two-frame window.
        for (int c = 0; c < 3; c++) step(1'b0, 2'd0, 24'h0);
        for (int c = 0; c < 200 && frame_start !== 1'b1; c++) step(1'b1, 2'd0, 24'h0);
        cnt_fs = 0; cnt_ls = 0; cnt_de = 0; cnt_hs_low = 0; cnt_vs_low = 0;
        for (int c = 0; c < 2 * FRAME; c++) step(1'b1, 2'd0, 24'h0);
        check_eq("win_frame_starts", 32'(cnt_fs), 32'd2);
        check_eq("win_line_starts", 32'(cnt_ls), 32'd8);
        check_eq("win_de_cycles", 32'(cnt_de), 32'd64);
        check_eq("win_hsync_low", 32'(cnt_hs_low), 32'd28);
        check_eq("win_vsync_low", 32'(cnt_vs_low), 32'd14 * 2);
        check_eq("frame_period", 32'(fs_gap), 32'(FRAME));

        // Colour bars requested mid-frame at v=2.
        for (int c = 0; c < FRAME && ((n / H_TOTAL) % V_TOTAL) != 2; c++) step(1'b1, 2'd0, 24'h0);
        for (int c = 0; c < 2 * FRAME; c++) step(1'b1, 2'd1, 24'h0);

        // Solid fill.
        for (int c = 0; c < 2 * FRAME; c++) step(1'b1, 2'd2, 24'h123456);

        // One-cycle reset at counters (5,2).
        for (int c = 0; c < 2 * FRAME && (n % FRAME) != 2 * H_TOTAL + 5; c++)
            step(1'b1, 2'd0, 24'h0);
        step(1'b0, 2'd0, 24'h0);
        for (int c = 0; c < FRAME + 10; c++) step(1'b1, 2'd0, 24'h0);

        // Randomized mode, fill and reset activity.
        for (int k = 0; k < 24; k++) begin
            rm  = 2'($urandom_range(0, 3));
            rf  = 24'($urandom);
            len = int'($urandom_range(1, 160));
            for (int c = 0; c < len; c++) step(1'b1, rm, rf);
            if ($urandom_range(0, 3) == 0) begin
                rlen = int'($urandom_range(1, 2));
                for (int c = 0; c < rlen; c++) step(1'b0, rm, rf);
            end
        end
        for (int c = 0; c < 2 * FRAME; c++) step(1'b1, 2'd3, 24'hA5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_gen.md
HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 720, SHALL set active pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/62/60, SHALL set horizontal front porch/sync/back porch widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, SHALL set active lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 9/6/30, SHALL set vertical front porch/sync/back porch in lines.
REQ-005 Parameters HS_POL/VS_POL, default 0, SHALL set asserted sync level (0 = active-low).
REQ-006 Parameter PIX_LAT, default 2, range 0..8, SHALL set pixel-source latency in cycles.
REQ-007 Parameter CW, default 8, SHALL set bits per colour channel; pixel width is 3*CW, ordered {R,G,B}.
REQ-008 Derived: H_TOTAL = sum of the H_* parameters, V_TOTAL = sum of the V_* parameters, XW = $clog2(H_TOTAL), YW = $clog2(V_TOTAL).
REQ-009 clk  input  1  pixel clock; the only clock.
REQ-010 rst  input  1  synchronous, active-low reset.
REQ-011 mode  input  2  pattern select: 0 pass-through, 1 colour bars, 2 solid fill, 3 treated as 0.
REQ-012 fill  input  3*CW  solid-fill colour.
REQ-013 pix_in  input  3*CW  pixel returned by the source, PIX_LAT cycles after its request.
REQ-014 req_valid/req_x/req_y  output  1/XW/YW  pixel request and coordinates.
REQ-015 data  output  3*CW  output pixel.
REQ-016 hsync/vsync/de  output  1 each  syncs and data enable.
REQ-017 frame_start/line_start  output  1 each  single-cycle markers.

Function
REQ-018 Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) SHALL advance h every cycle; h wraps to 0 after H_TOTAL-1, and v increments only on that wrap.
REQ-019 v SHALL wrap to 0 when h wraps while v = V_TOTAL-1.
REQ-020 Line order: active [0,H_ACTIVE), then FP, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP; vertical order is identical, in lines.
REQ-021 req_valid SHALL equal (h<H_ACTIVE && v<V_ACTIVE) combinationally from the counters, with req_x=h and req_y=v; req_x/req_y are don't-care when req_valid=0.
REQ-022 All other outputs SHALL be registered and reflect counter state (h,v) exactly L=PIX_LAT+1 cycles later, via a delay line carrying active, hsync, vsync, frame and line flags, and x.
REQ-023 de SHALL be the delayed active flag.
REQ-024 hsync/vsync SHALL equal HS_POL/VS_POL inside their sync windows and the inverse otherwise; vsync changes only at line boundaries.
REQ-025 frame_start SHALL be 1 when the output corresponds to (0,0); line_start SHALL be 1 when it corresponds to h=0 with v<V_ACTIVE.
REQ-026 When de=0, data SHALL be all-zero.
REQ-027 When de=1, mode_q=0: data SHALL be the pix_in value sampled PIX_LAT cycles after the matching request.
REQ-028 When de=1, mode_q=1: data SHALL show 8 bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black; each channel is all-ones or zero. H_ACTIVE must be a multiple of 8.
REQ-029 When de=1, mode_q=2: data SHALL be fill, sampled in the same cycle as pix_in.
REQ-030 mode_q SHALL load mode only on the cycle the counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0); a mid-frame mode change SHALL take effect at the next frame start.
REQ-031 For PIX_LAT=0, pix_in SHALL be sampled in the request cycle and L=1.

Reset
REQ-032 While rst=0 at a clock edge: h=0, v=0, mode_q<=mode, and every delay-line stage cleared to de=0, syncs deasserted, flags 0.
REQ-033 Outputs after reset: data=0, de=0, frame_start=0, line_start=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-034 The first cycle after rst=1 SHALL present counters (0,0), with req_valid=1 if H_ACTIVE and V_ACTIVE are nonzero.
REQ-035 A reset asserted mid-frame SHALL discard in-flight pipeline contents, with no partial pixels emitted.

Verification (bench params: H 8/2/2/2 so H_TOTAL=14; V 4/1/1/1 so V_TOTAL=7; PIX_LAT=2, so L=3; CW=8)
REQ-036 Release reset with mode=0 and pix_in={8'h00,x,y} delayed 2 -> de=0 for 3 cycles; at cycle 3, frame_start=1, de=1, data=000000.
REQ-037 Free-run one line -> de high for 8 cycles, then low for 6; hsync low for exactly output h=10,11; line period 14 cycles.
REQ-038 Free-run frames -> vsync low for exactly 14 cycles (v=5); frame_start period 98 cycles; line_start 4 times per frame.
REQ-039 Set mode=1 while v=2 -> data stays pass-through for the rest of the frame; next frame x=0 gives FFFFFF, x=5 gives FF0000, x=7 gives 000000.
REQ-040 Set mode=2 with fill=123456 -> from next frame, active pixels = 123456 and blanking = 000000.
REQ-041 Pulse rst=0 for one cycle at (h=5,v=2) -> next cycle req_x=0, req_y=0; de=0 for 3 cycles; then frame_start=1.
